// File: rtl/clk_period_meter_pkg.sv
// rtl/clk_period_meter_pkg.sv - shared types and constants for the period meter
// Purpose: measurement FSM state encoding and the counter-saturation helper.
// Ports: none (package).
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  // All-ones value of a counter of the given width (saturation ceiling).
  function automatic logic [63:0] cnt_max(input int unsigned width);
    if (width >= 64) cnt_max = {64{1'b1}};
    else             cnt_max = (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/clk_period_meter_toggle_detect.sv
// rtl/clk_period_meter_toggle_detect.sv - toggle detector with optional input synchroniser
// Purpose: flags every cycle in which the (optionally synchronised) wave differs
//          from its value on the previous clock.
// Macro:   CLK_PERIOD_METER_SYNC_EN adds a 2-flop synchroniser ahead of detection.
// Ports:
//   i_clk    in  1  system clock
//   i_rst_n  in  1  synchronous active-low reset
//   i_sig    in  1  wave under test
//   o_edge   out 1  combinational toggle flag (sampled by the parent FSM)
import clk_period_meter_pkg::*;

module toggle_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic w_s;
  logic r_sig_q;

`ifdef CLK_PERIOD_METER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_sig;
`endif

  // Previous sample is tracked in every FSM state so that re-arming never
  // sees a stale level as a fresh toggle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sig_q <= 1'b0;
    else          r_sig_q <= w_s;
  end

  assign o_edge = w_s ^ r_sig_q;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - half-period meter for a divided square wave
// Purpose: counts clk cycles between successive toggles of i_sig_in, reports
//          each run length, a lock flag for steady rates and a sticky timeout.
// Macro:   CLK_PERIOD_METER_SYNC_EN (see toggle_detect) adds 2 cycles of latency.
// Ports:
//   i_clk          in  1      system clock, sole domain
//   i_rst_n        in  1      synchronous active-low reset
//   i_enable       in  1      1 = measure, 0 = hold in IDLE
//   i_sig_in       in  1      wave under test
//   o_half_period  out WIDTH  cycles between the last two toggles
//   o_valid        out 1      one-cycle pulse when o_half_period updates
//   o_locked       out 1      last two measurements equal
//   o_timeout      out 1      sticky: no toggle for TIMEOUT cycles
import clk_period_meter_pkg::*;

module clk_period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_sig_in,
  output logic [WIDTH-1:0] o_half_period,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic w_edge;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_hp, w_hp_n;
  logic             r_valid, w_valid_n;
  logic             r_locked, w_locked_n;
  logic             r_timeout, w_timeout_n;
  // A previous measurement exists in the current MEAS session.
  logic             r_have_prev, w_have_prev_n;

  toggle_detect u_toggle_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sig_in),
    .o_edge  (w_edge)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hp        <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_hp        <= w_hp_n;
      r_valid     <= w_valid_n;
      r_locked    <= w_locked_n;
      r_timeout   <= w_timeout_n;
      r_have_prev <= w_have_prev_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_hp_n        = r_hp;
    w_valid_n     = 1'b0;
    w_locked_n    = r_locked;
    w_timeout_n   = r_timeout;
    w_have_prev_n = r_have_prev;

    // Disable dominates any toggle seen in the same cycle.
    if (!i_enable) begin
      w_state_n  = ST_IDLE;
      w_cnt_n    = '0;
      w_locked_n = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_n   = '0;
          w_state_n = ST_ARM;
        end
        ST_ARM: begin
          // First run is partial, so the first toggle only starts counting.
          if (w_edge) begin
            w_cnt_n       = ONE;
            w_have_prev_n = 1'b0;
            w_state_n     = ST_MEAS;
          end else if (r_cnt == TIMEOUT_C) begin
            w_timeout_n = 1'b1;
            w_cnt_n     = '0;
          end else begin
            w_cnt_n = r_cnt + ONE;
          end
        end
        ST_MEAS: begin
          // A toggle exactly at the timeout count is still a measurement.
          if (w_edge) begin
            w_hp_n        = r_cnt;
            w_valid_n     = 1'b1;
            w_locked_n    = r_have_prev && (r_cnt == r_hp);
            w_have_prev_n = 1'b1;
            w_timeout_n   = 1'b0;
            w_cnt_n       = ONE;
          end else if (r_cnt == TIMEOUT_C) begin
            w_timeout_n = 1'b1;
            w_locked_n  = 1'b0;
            w_cnt_n     = '0;
            w_state_n   = ST_ARM;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_n = r_cnt + ONE;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign o_half_period = r_hp;
  assign o_valid       = r_valid;
  assign o_locked      = r_locked;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter
module tb_clk_period_meter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 20;
`ifdef CLK_PERIOD_METER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] o_half_period;
  logic             o_valid;
  logic             o_locked;
  logic             o_timeout;

  clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_sig_in      (sig_in),
    .o_half_period (o_half_period),
    .o_valid       (o_valid),
    .o_locked      (o_locked),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Timestamp model: a measurement is the number of clk edges between two
  // observed toggles; timeouts are measured from the last toggle (or arm point).
  int  t = 0;
  bit  m_on, m_meas, m_have_prev, m_valid, m_locked, m_timeout, m_prev_s;
  bit  [1:0] m_dl;
  int  m_hp, m_last_t, m_arm_ref;

  always @(posedge clk) begin : model
    bit s;
    bit e;
    int gap;
    t++;
    s = SYNC ? m_dl[1] : sig_in;
    e = s ^ m_prev_s;
    m_prev_s = s;
    m_dl = {m_dl[0], sig_in};
    m_valid = 1'b0;
    if (!rst_n) begin
      m_on = 0; m_meas = 0; m_have_prev = 0; m_locked = 0; m_timeout = 0;
      m_hp = 0; m_prev_s = 0; m_dl = 2'b00;
    end else if (!enable) begin
      m_on = 0; m_meas = 0; m_locked = 0;
    end else if (!m_on) begin
      m_on = 1; m_meas = 0; m_arm_ref = t;
    end else if (!m_meas) begin
      if (e) begin
        m_meas = 1; m_last_t = t; m_have_prev = 0;
      end else if (t - m_arm_ref - 1 == TIMEOUT) begin
        m_timeout = 1; m_arm_ref = t;
      end
    end else begin
      gap = t - m_last_t;
      if (e) begin
        m_valid = 1;
        m_locked = m_have_prev && (gap == m_hp);
        m_hp = gap; m_have_prev = 1; m_timeout = 0; m_last_t = t;
      end else if (gap == TIMEOUT) begin
        m_timeout = 1; m_locked = 0; m_meas = 0; m_arm_ref = t;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("half_period", o_half_period, m_hp);
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("locked", {31'd0, o_locked}, {31'd0, m_locked});
    chk("timeout", {31'd0, o_timeout}, {31'd0, m_timeout});
  end

  logic [31:0] last_hp = '0;
  logic        last_lock = 1'b0;
  int          n_valid = 0;

  always @(negedge clk) begin : monitor
    if (o_valid) begin
      last_hp   = o_half_period;
      last_lock = o_locked;
      n_valid++;
    end
  end

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run(input int period, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i % period == 0) sig_in = ~sig_in;
    end
  endtask

  initial begin : stim
    int n0;
    rst_n = 1'b0;
    hold(3);
    chk("rst_half_period", o_half_period, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_locked", {31'd0, o_locked}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    run(5, 32); hold(4);
    chk("t1_hp", last_hp, 32'd5);
    chk("t1_locked", {31'd0, last_lock}, 32'd1);

    run(1, 10); hold(4);
    chk("t2_hp", last_hp, 32'd1);
    chk("t2_locked", {31'd0, last_lock}, 32'd1);

    hold(25);
    chk("t3_timeout", {31'd0, o_timeout}, 32'd1);
    chk("t3_locked", {31'd0, o_locked}, 32'd0);
    run(3, 20); hold(4);
    chk("t3_hp", last_hp, 32'd3);
    chk("t3_timeout_clr", {31'd0, o_timeout}, 32'd0);

    run(20, 42); hold(4);
    chk("bnd_hp", last_hp, 32'd20);
    chk("bnd_locked", {31'd0, last_lock}, 32'd1);
    chk("bnd_timeout", {31'd0, o_timeout}, 32'd0);

    n0 = n_valid;
    @(negedge clk); enable = 1'b0; sig_in = ~sig_in;
    @(negedge clk);
    @(negedge clk); sig_in = ~sig_in;
    @(negedge clk);
    hold(1);
    chk("t4_no_valid", n_valid, n0);
    chk("t4_locked", {31'd0, o_locked}, 32'd0);
    enable = 1'b1;
    run(5, 22); hold(4);
    chk("t4_hp", last_hp, 32'd5);
    chk("t4_locked_again", {31'd0, last_lock}, 32'd1);

    run(5, 12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_hp", o_half_period, 32'd0);
    chk("t5_valid", {31'd0, o_valid}, 32'd0);
    chk("t5_locked", {31'd0, o_locked}, 32'd0);
    chk("t5_timeout", {31'd0, o_timeout}, 32'd0);
    run(5, 32); hold(4);
    chk("t5_hp_after", last_hp, 32'd5);
    chk("t5_locked_after", {31'd0, last_lock}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
